// File: rtl/axi_sram_slave_if.sv
// rtl/axi_sram_slave_if.sv - AXI3 read/write channel bundle between CPU master and SRAM slave
interface axi_sram_slave_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - single-outstanding AXI3 slave driving one synchronous single-port SRAM
module axi_sram_slave #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axi_sram_slave_if.slave       axi,
  output logic                  ram_en,
  output logic [3:0]            ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_BEAT, WR_DATA, WR_RESP} state_t;

  state_t                state_q, state_d;
  logic                  prio_q, prio_d;
  logic [3:0]            id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] inc_q, inc_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic arready, awready, rvalid, rlast, wready, bvalid;
  logic [1:0] rresp, bresp;
  logic rd_grant, wr_grant, last_beat;
  logic [ADDR_WIDTH-1:0] next_addr;

  // Sub-word sizes collapse to a zero increment so narrow bursts stay on one word.
  function automatic logic [ADDR_WIDTH-1:0] burst_inc(input logic [2:0] size, input logic [1:0] burst);
    logic [7:0] bytes;
    bytes = 8'd1 << size;
    if (burst == 2'b00) return '0;
    return ADDR_WIDTH'(bytes >> 2);
  endfunction

  function automatic logic burst_err(input logic [7:0] len, input logic [1:0] burst);
    return burst[1] || (len[7:4] != 4'd0);
  endfunction

  assign rd_grant  = axi.arvalid && (!axi.awvalid || !prio_q);
  assign wr_grant  = axi.awvalid && !rd_grant;
  assign last_beat = (cnt_q == 4'd0);
  assign next_addr = addr_q + inc_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      inc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      inc_q   <= inc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    id_d    = id_q;
    addr_d  = addr_q;
    inc_d   = inc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    arready = 1'b0;
    awready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    rresp   = 2'b00;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bresp   = 2'b00;
    ram_en  = 1'b0;
    ram_wen = 4'b0000;
    case (state_q)
      IDLE: begin
        if (rd_grant) begin
          arready = 1'b1;
          prio_d  = 1'b1;
          id_d    = axi.arid;
          addr_d  = axi.araddr[ADDR_WIDTH+1:2];
          cnt_d   = axi.arlen[3:0];
          inc_d   = burst_inc(axi.arsize, axi.arburst);
          err_d   = burst_err(axi.arlen, axi.arburst);
          state_d = RD_ISSUE;
        end else if (wr_grant) begin
          awready = 1'b1;
          prio_d  = 1'b0;
          id_d    = axi.awid;
          addr_d  = axi.awaddr[ADDR_WIDTH+1:2];
          cnt_d   = axi.awlen[3:0];
          inc_d   = burst_inc(axi.awsize, axi.awburst);
          err_d   = burst_err(axi.awlen, axi.awburst);
          state_d = WR_DATA;
        end
      end
      RD_ISSUE: begin
        ram_en  = 1'b1;
        state_d = RD_BEAT;
      end
      RD_BEAT: begin
        // No SRAM access here, so rdata holds through any rready stall.
        rvalid = 1'b1;
        rlast  = last_beat;
        rresp  = err_q ? 2'b10 : 2'b00;
        if (axi.rready) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q - 4'd1;
            addr_d  = next_addr;
            state_d = RD_ISSUE;
          end
        end
      end
      WR_DATA: begin
        wready = 1'b1;
        if (axi.wvalid) begin
          ram_en  = 1'b1;
          ram_wen = axi.wstrb;
          if (axi.wlast != last_beat) err_d = 1'b1;
          if (last_beat) begin
            state_d = WR_RESP;
          end else begin
            cnt_d  = cnt_q - 4'd1;
            addr_d = next_addr;
          end
        end
      end
      WR_RESP: begin
        bvalid = 1'b1;
        bresp  = err_q ? 2'b10 : 2'b00;
        if (axi.bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign axi.arready = arready;
  assign axi.awready = awready;
  assign axi.rvalid  = rvalid;
  assign axi.rlast   = rlast;
  assign axi.rresp   = rresp;
  assign axi.rid     = id_q;
  assign axi.rdata   = ram_rdata;
  assign axi.wready  = wready;
  assign axi.bvalid  = bvalid;
  assign axi.bresp   = bresp;
  assign axi.bid     = id_q;

  assign ram_addr  = addr_q;
  assign ram_wdata = axi.wdata;

  logic unused_ok;
  assign unused_ok = ^{axi.araddr, axi.awaddr, axi.arlock, axi.arcache, axi.arprot,
                       axi.awlock, axi.awcache, axi.awprot, axi.wid};

endmodule
